run_length_tx: RTL and testbench



---
 rtl/run_length_tx.sv | 148 ++++++++++++++
 tb/tb_run_length_tx.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/run_length_tx.sv
// run_length_tx: serial run-length transmitter.
// Accepts (bit, length) run descriptors on a valid/ready handshake and emits
// them on w, one bit per clock, with back-to-back runs and no bubbles.
// Optional build macro RUN_LENGTH_TX_ZEXP_EN adds a predicted detector flag
// (z_exp) that is high on the 4th and later bits of a streak of equal bits.
module run_length_tx #(
  parameter int unsigned LEN_W = 4
) (
  input  logic             clk,
  input  logic             aclr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_bit,
  input  logic [LEN_W-1:0] in_len,
  output logic             w,
  output logic             w_valid,
  output logic             last,
  output logic             busy,
  output logic             z_exp
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t           state_q, state_d;
  logic             cur_bit_q, cur_bit_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             pend_bit_q, pend_bit_d;
  logic [LEN_W-1:0] pend_len_q, pend_len_d;
  logic             pend_v_q, pend_v_d;
  logic             accept;
  logic             acc_nz;

  // Ready depends only on the pending slot, never on in_valid
  assign in_ready = !pend_v_q;
  assign accept   = in_valid && in_ready;
  assign acc_nz   = accept && (in_len != '0);

  // Next-state: load runs, chain the pending slot, count down the current run
  always_comb begin
    state_d    = state_q;
    cur_bit_d  = cur_bit_q;
    cnt_d      = cnt_q;
    pend_bit_d = pend_bit_q;
    pend_len_d = pend_len_q;
    pend_v_d   = pend_v_q;
    case (state_q)
      IDLE: begin
        if (acc_nz) begin
          cur_bit_d = in_bit;
          cnt_d     = in_len;
          state_d   = SEND;
        end
      end
      SEND: begin
        if (cnt_q == LEN_W'(1)) begin
          if (pend_v_q) begin
            cur_bit_d = pend_bit_q;
            cnt_d     = pend_len_q;
            pend_v_d  = 1'b0;
          end else if (acc_nz) begin
            cur_bit_d = in_bit;
            cnt_d     = in_len;
          end else begin
            cnt_d   = '0;
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - LEN_W'(1);
          if (acc_nz) begin
            pend_bit_d = in_bit;
            pend_len_d = in_len;
            pend_v_d   = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs, all derived from the next state
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      state_q    <= IDLE;
      cur_bit_q  <= 1'b0;
      cnt_q      <= '0;
      pend_bit_q <= 1'b0;
      pend_len_q <= '0;
      pend_v_q   <= 1'b0;
      w          <= 1'b0;
      w_valid    <= 1'b0;
      last       <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_bit_q  <= cur_bit_d;
      cnt_q      <= cnt_d;
      pend_bit_q <= pend_bit_d;
      pend_len_q <= pend_len_d;
      pend_v_q   <= pend_v_d;
      w          <= cur_bit_d;
      w_valid    <= (state_d == SEND);
      last       <= (state_d == SEND) && (cnt_d == LEN_W'(1));
      busy       <= (state_d == SEND) || pend_v_d;
    end
  end

`ifdef RUN_LENGTH_TX_ZEXP_EN
  // Streak code 0..3 means 1..>=4 consecutive equal valid bits
  logic [1:0] streak_q, streak_d;
  logic       prev_q;
  logic       have_q;
  logic       z_d;

  // Streak update for the bit about to be presented on w
  always_comb begin
    streak_d = streak_q;
    z_d      = 1'b0;
    if (state_d == SEND) begin
      if (have_q && (cur_bit_d == prev_q)) begin
        streak_d = (streak_q == 2'd3) ? 2'd3 : streak_q + 2'd1;
      end else begin
        streak_d = 2'd0;
      end
      z_d = (streak_d == 2'd3);
    end
  end

  // Streak registers advance only on valid bits; idle cycles leave them alone
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      streak_q <= 2'd0;
      prev_q   <= 1'b0;
      have_q   <= 1'b0;
      z_exp    <= 1'b0;
    end else begin
      z_exp <= z_d;
      if (state_d == SEND) begin
        streak_q <= streak_d;
        prev_q   <= cur_bit_d;
        have_q   <= 1'b1;
      end
    end
  end
`else
  assign z_exp = 1'b0;
`endif

endmodule

// File: tb/tb_run_length_tx.sv
// Testbench for run_length_tx: random and directed runs, scoreboard checking.
module tb_run_length_tx;

  localparam int unsigned LEN_W = 4;
`ifdef RUN_LENGTH_TX_ZEXP_EN
  localparam bit ZEXP = 1'b1;
`else
  localparam bit ZEXP = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             aclr;
  logic             in_valid;
  logic             in_ready;
  logic             in_bit;
  logic [LEN_W-1:0] in_len;
  logic             w;
  logic             w_valid;
  logic             last;
  logic             busy;
  logic             z_exp;

  run_length_tx #(.LEN_W(LEN_W)) dut (
    .clk(clk), .aclr(aclr), .in_valid(in_valid), .in_ready(in_ready),
    .in_bit(in_bit), .in_len(in_len), .w(w), .w_valid(w_valid),
    .last(last), .busy(busy), .z_exp(z_exp)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic b;
    logic l;
    logic z;
    int   id;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   bits_seen = 0;
  int   next_id  = 0;
  // Reference streak model over the stream of transmitted bits
  int   m_streak = 0;
  logic m_prev   = 1'b0;
  bit   m_have   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expand an accepted descriptor into the bits it must produce
  task automatic model_push(input logic b, input int len);
    exp_t e;
    for (int i = 0; i < len; i++) begin
      if (m_have && (b == m_prev)) m_streak = (m_streak >= 4) ? 4 : m_streak + 1;
      else m_streak = 1;
      m_prev = b;
      m_have = 1'b1;
      e.b  = b;
      e.l  = (i == len - 1);
      e.z  = ZEXP && (m_streak >= 4);
      e.id = next_id;
      q.push_back(e);
    end
    next_id++;
  endtask

  task automatic model_reset();
    q.delete();
    m_streak = 0;
    m_have   = 1'b0;
    m_prev   = 1'b0;
  endtask

  // Offer one descriptor at a negedge; returns at the negedge after its accept
  task automatic send(input logic b, input int len);
    int waited = 0;
    in_valid = 1'b1;
    in_bit   = b;
    in_len   = LEN_W'(len);
    while (!in_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      check("send_ready_timeout", 32'(in_ready), 32'(1));
    end else begin
      @(posedge clk);
      #1;
      model_push(b, len);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: stream presence, pending state and each emitted bit vs the model
  always @(negedge clk) begin
    bit pend;
    pend = (q.size() > 1) && (q[0].id != q[q.size()-1].id);
    check("w_valid", 32'(w_valid), 32'(q.size() != 0));
    check("busy", 32'(busy), 32'(q.size() != 0));
    check("in_ready", 32'(in_ready), 32'(!pend));
    if (w_valid && q.size() != 0) begin
      check("w", 32'(w), 32'(q[0].b));
      check("last", 32'(last), 32'(q[0].l));
      check("z_exp", 32'(z_exp), 32'(q[0].z));
      void'(q.pop_front());
      bits_seen++;
    end else if (!w_valid) begin
      check("last_idle", 32'(last), 32'(0));
      check("z_exp_idle", 32'(z_exp), 32'(0));
    end
  end

  initial begin
    int base;
    int waited;
    int gap;
    aclr     = 1'b1;
    in_valid = 1'b0;
    in_bit   = 1'b0;
    in_len   = '0;
    repeat (2) @(negedge clk);
    aclr = 1'b0;

    // Quiet after reset
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      check("rst_w", 32'(w), 32'(0));
      check("rst_valid", 32'(w_valid), 32'(0));
    end

    // Single run, back-to-back runs, zero length, streak pattern, max length
    send(1'b1, 3);  idle(6);
    send(1'b0, 2);  send(1'b1, 4);  idle(8);
    send(1'b1, 0);  send(1'b0, 1);  idle(4);
    send(1'b0, 3);  send(1'b0, 2);  send(1'b1, 5);  idle(14);
    send(1'b1, 15); idle(18);

    // Max-length run with a pending second run, killed by aclr mid-run
    base = bits_seen;
    send(1'b1, 15);
    send(1'b1, 15);
    waited = 0;
    while (bits_seen < base + 7 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    check("bits_before_aclr", 32'(bits_seen >= base + 7), 32'(1));
    @(posedge clk);
    #2;
    check("valid_before_aclr", 32'(w_valid), 32'(1));
    check("ready_before_aclr", 32'(in_ready), 32'(0));
    aclr = 1'b1;
    model_reset();
    #1;
    check("aclr_valid", 32'(w_valid), 32'(0));
    check("aclr_ready", 32'(in_ready), 32'(1));
    check("aclr_busy", 32'(busy), 32'(0));
    check("aclr_last", 32'(last), 32'(0));
    check("aclr_w", 32'(w), 32'(0));
    @(negedge clk);
    aclr = 1'b0;
    idle(2);
    send(1'b0, 2);  idle(5);

    // Random descriptors with random gaps
    for (int i = 0; i < 300; i++) begin
      send(1'($urandom_range(0, 1)), int'($urandom_range(0, 15)));
      gap = int'($urandom_range(0, 5));
      if (gap > 3) idle(gap);
    end

    waited = 0;
    while (q.size() != 0 && waited < 400) begin
      @(negedge clk);
      waited++;
    end
    check("drain", 32'(q.size()), 32'(0));
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
